// File: rtl/bsg_arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority hold arbiter.
package bsg_arb_pkg;

    typedef enum logic {
        search_hi_to_lo_e = 1'b0,
        search_lo_to_hi_e = 1'b1
    } search_dir_e;

    localparam int unsigned arb_mode_fixed_c = 0;
    localparam int unsigned arb_mode_rr_c    = 1;

    // The pointer starts just "behind" the preferred end, so the first search begins there.
    function automatic int unsigned arb_ptr_reset(input int unsigned inputs, input int unsigned lo_to_hi);
        return (lo_to_hi != 0) ? inputs - 1 : 0;
    endfunction

endpackage

// File: rtl/bsg_arb_rr_mask_enc.sv
// Rotating-start search: requests strictly past ptr win first, otherwise wrap to the full vector.
module bsg_arb_rr_mask_enc
    import bsg_arb_pkg::*;
#(
    parameter int unsigned inputs_p     = 16,
    parameter int unsigned lo_to_hi_p   = 0,
    parameter int unsigned lg_inputs_lp = $clog2(inputs_p)
) (
    input  logic [inputs_p-1:0]     reqs,
    input  logic [lg_inputs_lp-1:0] ptr,
    output logic [inputs_p-1:0]     one_hot,
    output logic [lg_inputs_lp-1:0] id,
    output logic                    v
);

    localparam search_dir_e dir_lp = (lo_to_hi_p != 0) ? search_lo_to_hi_e : search_hi_to_lo_e;
    localparam int unsigned enc_dir_lp = (dir_lp == search_lo_to_hi_e) ? 1 : 0;

    logic [inputs_p-1:0] mask;
    logic [inputs_p-1:0] masked_oh;
    logic [inputs_p-1:0] full_oh;
    logic                masked_v;
    logic                full_v;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < inputs_p; i++) begin
            if (dir_lp == search_lo_to_hi_e) mask[i] = (i > 32'(ptr));
            else                             mask[i] = (i < 32'(ptr));
        end
    end

    bsg_priority_encode_one_hot_out #(
        .width_p    (inputs_p),
        .lo_to_hi_p (enc_dir_lp)
    ) u_masked (
        .reqs    (reqs & mask),
        .one_hot (masked_oh),
        .v       (masked_v)
    );

    bsg_priority_encode_one_hot_out #(
        .width_p    (inputs_p),
        .lo_to_hi_p (enc_dir_lp)
    ) u_full (
        .reqs    (reqs),
        .one_hot (full_oh),
        .v       (full_v)
    );

    always_comb begin
        one_hot = masked_v ? masked_oh : full_oh;
        v       = full_v;
        id      = '0;
        for (int unsigned i = 0; i < inputs_p; i++) begin
            if (one_hot[i]) id = id | lg_inputs_lp'(i);
        end
    end

endmodule

// File: rtl/bsg_priority_encode_one_hot_out.sv
// Priority encoder returning the first set request as a one-hot vector.
module bsg_priority_encode_one_hot_out #(
    parameter int unsigned width_p    = 4,
    parameter int unsigned lo_to_hi_p = 1
) (
    input  logic [width_p-1:0] reqs,
    output logic [width_p-1:0] one_hot,
    output logic               v
);

    logic seen;

    always_comb begin
        one_hot = '0;
        seen    = 1'b0;
        if (lo_to_hi_p != 0) begin
            for (int unsigned j = 0; j < width_p; j++) begin
                if (reqs[j] && !seen) begin
                    one_hot[j] = 1'b1;
                    seen       = 1'b1;
                end
            end
        end else begin
            for (int unsigned j = width_p; j > 0; j--) begin
                if (reqs[j-1] && !seen) begin
                    one_hot[j-1] = 1'b1;
                    seen         = 1'b1;
                end
            end
        end
        v = |reqs;
    end

endmodule

// File: rtl/bsg_arb_rr_hold.sv
// N-way round-robin / fixed-priority arbiter with optional grant lock for multi-beat transfers.
module bsg_arb_rr_hold
    import bsg_arb_pkg::*;
#(
    parameter int unsigned inputs_p   = 16,
    parameter int unsigned lo_to_hi_p = 0,
    parameter int unsigned rr_mode_p  = 1,
    parameter int unsigned hold_en_p  = 1,
    localparam int unsigned lg_inputs_lp = $clog2(inputs_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [inputs_p-1:0]     reqs_i,
    input  logic                    ready_i,
    input  logic                    hold_i,
    output logic [inputs_p-1:0]     grants_o,
    output logic [lg_inputs_lp-1:0] grant_id_o,
    output logic                    v_o,
    output logic                    locked_o
);

    localparam logic [lg_inputs_lp-1:0] ptr_reset_lp =
        lg_inputs_lp'(arb_ptr_reset(inputs_p, lo_to_hi_p));
    localparam logic hold_en_lp = (hold_en_p != 0);

    logic [lg_inputs_lp-1:0] ptr_r, owner_r, search_ptr, enc_id, win_id;
    logic [inputs_p-1:0]     enc_oh, win_oh;
    logic                    lock_r, enc_v, win_v, owner_req, accept;

    assign search_ptr = (rr_mode_p == arb_mode_fixed_c) ? ptr_reset_lp : ptr_r;

    bsg_arb_rr_mask_enc #(
        .inputs_p   (inputs_p),
        .lo_to_hi_p (lo_to_hi_p)
    ) u_enc (
        .reqs    (reqs_i),
        .ptr     (search_ptr),
        .one_hot (enc_oh),
        .id      (enc_id),
        .v       (enc_v)
    );

    assign owner_req = reqs_i[owner_r];

    // While locked, only the owner can win; if it drops its request nobody wins this cycle.
    always_comb begin
        win_oh = enc_oh;
        win_id = enc_id;
        win_v  = enc_v;
        if (lock_r) begin
            win_oh          = '0;
            win_oh[owner_r] = owner_req;
            win_id          = owner_req ? owner_r : '0;
            win_v           = owner_req;
        end
        if (!reset_n_i) begin
            win_oh = '0;
            win_id = '0;
            win_v  = 1'b0;
        end
    end

    assign accept     = win_v & ready_i;
    assign grants_o   = win_oh & {inputs_p{ready_i}};
    assign grant_id_o = win_id;
    assign v_o        = win_v;
    assign locked_o   = lock_r & owner_req & reset_n_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r   <= ptr_reset_lp;
            lock_r  <= 1'b0;
            owner_r <= '0;
        end else if (accept) begin
            if (rr_mode_p == arb_mode_rr_c) ptr_r <= win_id;
            lock_r  <= hold_i & hold_en_lp;
            owner_r <= win_id;
        end else if (lock_r && !owner_req) begin
            lock_r <= 1'b0;
        end
    end

    a_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(grants_o));
    a_req_only: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (grants_o & ~reqs_i) == '0);
    a_owner_only: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        locked_o |-> ((grants_o & ~(inputs_p'(1) << owner_r)) == '0));

endmodule

// File: tb/tb_bsg_arb_rr_hold.sv
// Directed bench for bsg_arb_rr_hold: rr, fixed priority, lock, ready gating, async reset.
module tb_bsg_arb_rr_hold;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_c, ready, hold;
    logic [3:0]  reqs_a, reqs_b;
    logic [15:0] reqs_c;

    logic [3:0]  grants_a, grants_b, grants_d;
    logic [1:0]  id_a, id_b, id_d;
    logic        v_a, v_b, v_d, locked_a, locked_b, locked_d;
    logic [15:0] grants_c;
    logic [3:0]  id_c;
    logic        v_c, locked_c;

    int n_checks = 0;
    int n_errors = 0;

    bsg_arb_rr_hold #(.inputs_p(4), .lo_to_hi_p(1), .rr_mode_p(1), .hold_en_p(1)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .reqs_i(reqs_a), .ready_i(ready), .hold_i(hold),
        .grants_o(grants_a), .grant_id_o(id_a), .v_o(v_a), .locked_o(locked_a));

    bsg_arb_rr_hold #(.inputs_p(4), .lo_to_hi_p(0), .rr_mode_p(0), .hold_en_p(1)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .reqs_i(reqs_b), .ready_i(ready), .hold_i(1'b0),
        .grants_o(grants_b), .grant_id_o(id_b), .v_o(v_b), .locked_o(locked_b));

    bsg_arb_rr_hold #(.inputs_p(4), .lo_to_hi_p(1), .rr_mode_p(1), .hold_en_p(0)) dut_d (
        .clk_i(clk), .reset_n_i(rst_n), .reqs_i(reqs_a), .ready_i(ready), .hold_i(hold),
        .grants_o(grants_d), .grant_id_o(id_d), .v_o(v_d), .locked_o(locked_d));

    bsg_arb_rr_hold #(.inputs_p(16), .lo_to_hi_p(1), .rr_mode_p(1), .hold_en_p(1)) dut_c (
        .clk_i(clk), .reset_n_i(rst_c), .reqs_i(reqs_c), .ready_i(ready), .hold_i(hold),
        .grants_o(grants_c), .grant_id_o(id_c), .v_o(v_c), .locked_o(locked_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [3:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       hold_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_lock_g [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    logic       exp_lock_l [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0; rst_c = 1'b0; ready = 1'b1; hold = 1'b0;
        reqs_a = 4'b1111; reqs_b = 4'b0101; reqs_c = 16'hFFFF;
        #2;
        check("reset_grants", 32'(grants_a), 32'h0);
        check("reset_v", 32'(v_a), 32'h0);
        check("reset_id", 32'(id_a), 32'h0);
        check("reset_locked", 32'(locked_a), 32'h0);
        check("reset_grants_c", 32'(grants_c), 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; rst_c = 1'b1; reqs_c = '0;

        // rr sweep on A/D, fixed priority on B
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("rr_grants", 32'(grants_a), 32'(exp_rr[i]));
            check("rr_id", 32'(id_a), 32'(exp_id[i]));
            check("rr_nohold_grants", 32'(grants_d), 32'(exp_rr[i]));
            check("rr_nohold_v", 32'(v_d), 32'h1);
            check("fixed_grants", 32'(grants_b), 32'b0100);
            check("fixed_id", 32'(id_b), 32'h2);
            check("fixed_v", 32'(v_b), 32'h1);
            check("fixed_locked", 32'(locked_b), 32'h0);
        end

        // lock on idx1 for 3 held beats plus a release beat
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            hold = hold_seq[i];
            #1;
            check("lock_grants", 32'(grants_a), 32'(exp_lock_g[i]));
            check("lock_locked", 32'(locked_a), 32'(exp_lock_l[i]));
            check("nohold_locked", 32'(locked_d), 32'h0);
        end

        // ready low: winner visible, nothing granted, pointer stays at 2
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            hold = 1'b0; ready = 1'b0; reqs_a = 4'b0110;
            #1;
            check("nordy_v", 32'(v_a), 32'h1);
            check("nordy_id", 32'(id_a), 32'h1);
            check("nordy_grants", 32'(grants_a), 32'h0);
        end
        @(negedge clk);
        ready = 1'b1;
        #1;
        check("rdy_grants", 32'(grants_a), 32'b0010);

        // lock to idx2, others masked, then owner drops
        @(negedge clk);
        reqs_a = 4'b0100; hold = 1'b1;
        #1;
        check("own_grants", 32'(grants_a), 32'b0100);
        @(negedge clk);
        reqs_a = 4'b1111;
        #1;
        check("own_masked", 32'(grants_a), 32'b0100);
        check("own_locked", 32'(locked_a), 32'h1);
        @(negedge clk);
        reqs_a = 4'b1011;
        #1;
        check("drop_locked", 32'(locked_a), 32'h0);
        check("drop_v", 32'(v_a), 32'h0);
        check("drop_grants", 32'(grants_a), 32'h0);
        @(negedge clk);
        reqs_a = 4'b1001; hold = 1'b0;
        #1;
        check("after_drop", 32'(grants_a), 32'b1000);

        // 16-way: lock owner 9, async reset mid-lock, restart from idx 0
        @(negedge clk);
        reqs_c = 16'h0200; hold = 1'b1;
        #1;
        check("c_id", 32'(id_c), 32'd9);
        @(negedge clk);
        #1;
        check("c_locked", 32'(locked_c), 32'h1);
        #2;
        rst_c = 1'b0;
        #1;
        check("c_rst_locked", 32'(locked_c), 32'h0);
        check("c_rst_grants", 32'(grants_c), 32'h0);
        check("c_rst_v", 32'(v_c), 32'h0);
        @(negedge clk);
        rst_c = 1'b1; reqs_c = 16'hFFFF; hold = 1'b0;
        #1;
        check("c_restart_id", 32'(id_c), 32'd0);
        check("c_restart_grants", 32'(grants_c), 32'h0001);
        @(negedge clk);
        #1;
        check("c_next_id", 32'(id_c), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
